mips_regfile: RTL and testbench

Parametrised general-purpose register file for the MIPS integer core, successor to the fixed 32×32 file. It keeps byte-lane writes, two combinational read ports and a hard-wired zero register, and adds three things. Width and depth are configurable. A post-reset clear engine zeroes every register. A per-register load-pending scoreboard lets the decode stage detect load-use hazards. It sits between decode (rs/rt reads, hazard query) and writeback (rd/we/D).

---
 rtl/mips_regfile.sv | 111 +++++++++++
 tb/tb_mips_regfile.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mips_regfile.sv
// Parametrised MIPS GPR file: byte-lane writes, 0-cycle reads, post-reset clear engine, load-pending scoreboard.
// MIPS_REGFILE_BYPASS_EN forwards same-cycle writeback data and masks the wait flags; writes/loads are dropped until ready.
module mips_regfile #(
   parameter  int WIDTH = 32,
   parameter  int DEPTH = 32,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic [AW-1:0]        rd,
   input  logic [WIDTH/8-1:0]   we,
   input  logic [WIDTH-1:0]     D,
   input  logic                 ld_set,
   input  logic [AW-1:0]        ld_rd,
   input  logic [AW-1:0]        rs,
   input  logic [AW-1:0]        rt,
   output logic [WIDTH-1:0]     S,
   output logic [WIDTH-1:0]     T,
   output logic                 s_wait,
   output logic                 t_wait,
   output logic                 ready
);

   localparam int NL = WIDTH / 8;

   typedef enum logic {CLEAR, RUN} state_e;

   state_e           state_q, state_d;
   logic [AW-1:0]    cnt_q, cnt_d;
   logic [DEPTH-1:0] pend_q, pend_d;
   logic             clr_wr, run_wr, ld_hit, s_byp, t_byp;
   logic [WIDTH-1:0] s_mem, t_mem;

   assign ready  = (state_q == RUN);
   assign clr_wr = (state_q == CLEAR);
   assign run_wr = ready && (|we) && (rd != '0);
   assign ld_hit = ready && ld_set && (ld_rd != '0);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= CLEAR;
         cnt_q   <= AW'(1);
         pend_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == CLEAR) begin
         cnt_d = cnt_q + AW'(1);
         if (cnt_q == AW'(DEPTH - 1)) begin
            state_d = RUN;
         end
      end
   end

   // A load issued on the same edge as the writeback to its register wins: it is newer.
   always_comb begin
      pend_d = pend_q;
      if (run_wr) begin
         pend_d[rd] = 1'b0;
      end
      if (ld_hit) begin
         pend_d[ld_rd] = 1'b1;
      end
      pend_d[0] = 1'b0;
   end

   // Register 0 has no storage; its reads are forced to zero below.
   for (genvar l = 0; l < NL; l++) begin : g_lane
      logic [7:0] mem_q [1:DEPTH-1];

      always_ff @(posedge clock) begin
         if (clr_wr) begin
            mem_q[cnt_q] <= '0;
         end else if (run_wr && we[l]) begin
            mem_q[rd] <= D[8*l +: 8];
         end
      end

      assign s_mem[8*l +: 8] = mem_q[rs];
      assign t_mem[8*l +: 8] = mem_q[rt];
   end

   always_comb begin
      s_byp = 1'b0;
      t_byp = 1'b0;
`ifdef MIPS_REGFILE_BYPASS_EN
      s_byp = run_wr && (rs == rd);
      t_byp = run_wr && (rt == rd);
`endif
      S = '0;
      T = '0;
      for (int l = 0; l < NL; l++) begin
         if (ready && (rs != '0)) begin
            S[8*l +: 8] = (s_byp && we[l]) ? D[8*l +: 8] : s_mem[8*l +: 8];
         end
         if (ready && (rt != '0)) begin
            T[8*l +: 8] = (t_byp && we[l]) ? D[8*l +: 8] : t_mem[8*l +: 8];
         end
      end
      s_wait = ready && pend_q[rs] && !s_byp;
      t_wait = ready && pend_q[rt] && !t_byp;
   end

endmodule

// File: tb/tb_mips_regfile.sv
// Directed bench for mips_regfile: 32x32 instance plus a 64-bit x 8 instance.
module tb_mips_regfile;

   logic        clk = 1'b0;
   logic        rst_a, rst_b;
   int          errors = 0;
   int          checks = 0;

   logic [4:0]  rd, ld_rd, rs, rt;
   logic [3:0]  we;
   logic [31:0] D, S, T;
   logic        ld_set, s_wait, t_wait, ready;

   logic [2:0]  rd_b, ld_rd_b, rs_b, rt_b;
   logic [7:0]  we_b;
   logic [63:0] D_b, S_b, T_b;
   logic        ld_set_b, s_wait_b, t_wait_b, ready_b;

   localparam logic BYP =
`ifdef MIPS_REGFILE_BYPASS_EN
      1'b1;
`else
      1'b0;
`endif

   always #5 clk = ~clk;

   mips_regfile #(.WIDTH(32), .DEPTH(32)) u_a (
      .clock(clk), .reset_n(rst_a), .rd(rd), .we(we), .D(D),
      .ld_set(ld_set), .ld_rd(ld_rd), .rs(rs), .rt(rt),
      .S(S), .T(T), .s_wait(s_wait), .t_wait(t_wait), .ready(ready)
   );

   mips_regfile #(.WIDTH(64), .DEPTH(8)) u_b (
      .clock(clk), .reset_n(rst_b), .rd(rd_b), .we(we_b), .D(D_b),
      .ld_set(ld_set_b), .ld_rd(ld_rd_b), .rs(rs_b), .rt(rt_b),
      .S(S_b), .T(T_b), .s_wait(s_wait_b), .t_wait(t_wait_b), .ready(ready_b)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   task automatic edge_();
      @(posedge clk);
      #2;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_a = 1'b0; rst_b = 1'b0;
      rd = 5'd3; we = 4'hF; D = 32'hFFFF_FFFF; ld_set = 1'b1; ld_rd = 5'd3; rs = 5'd3; rt = 5'd0;
      rd_b = '0; we_b = '0; D_b = '0; ld_set_b = 1'b0; ld_rd_b = '0; rs_b = '0; rt_b = '0;
      #12;
      chk("rst_ready", 64'(ready), 64'd0);
      chk("rst_S", 64'(S), 64'd0);
      chk("rst_T", 64'(T), 64'd0);
      chk("rst_swait", 64'(s_wait), 64'd0);
      chk("rst_b_ready", 64'(ready_b), 64'd0);
      chk("rst_b_waits", 64'({s_wait_b, t_wait_b}), 64'd0);
      rst_a = 1'b1; rst_b = 1'b1;

      // Clear phase with write/load requests held high on A; they must be ignored.
      for (int k = 1; k <= 31; k++) begin
         edge_();
         if (k == 6)  chk("b_ready_e6", 64'(ready_b), 64'd0);
         if (k == 7)  chk("b_ready_e7", 64'(ready_b), 64'd1);
         if (k == 10) chk("clr_S", 64'(S), 64'd0);
         if (k == 10) chk("clr_swait", 64'(s_wait), 64'd0);
         if (k == 30) begin
            chk("ready_e30", 64'(ready), 64'd0);
            we = 4'h0; ld_set = 1'b0;
         end
         if (k == 31) chk("ready_e31", 64'(ready), 64'd1);
      end
      #1;
      chk("clr_ignored_S3", 64'(S), 64'd0);
      chk("clr_ignored_wait3", 64'(s_wait), 64'd0);
      for (int i = 0; i < 32; i++) begin
         rs = 5'(i); rt = 5'(31 - i);
         #1;
         chk($sformatf("zero_S%0d", i), 64'(S), 64'd0);
         chk($sformatf("zero_T%0d", 31 - i), 64'(T), 64'd0);
      end

      // Byte-lane merge and discarded r0 write.
      edge_();
      rd = 5'd5; D = 32'hA1B2_C3D4; we = 4'hF;
      edge_();
      D = 32'hFFFF_FFFF; we = 4'b0101;
      edge_();
      we = 4'h0; rs = 5'd5;
      #1 chk("lane_merge", 64'(S), 64'hA1FF_C3FF);
      rd = 5'd0; D = 32'h1234_5678; we = 4'hF;
      edge_();
      we = 4'h0; rt = 5'd0;
      #1 chk("r0_read", 64'(T), 64'd0);

      // Scoreboard set and writeback clear on r7.
      ld_set = 1'b1; ld_rd = 5'd7; rs = 5'd7;
      #1 chk("pend7_before", 64'(s_wait), 64'd0);
      edge_();
      ld_set = 1'b0;
      #1 chk("pend7_set", 64'(s_wait), 64'd1);
      rd = 5'd7; we = 4'b0001; D = 32'h0000_0077;
      #1 chk("pend7_wb_cycle", 64'(s_wait), BYP ? 64'd0 : 64'd1);
      edge_();
      we = 4'h0;
      #1 chk("pend7_cleared", 64'(s_wait), 64'd0);

      // Same-edge load and writeback on r9: set wins.
      ld_set = 1'b1; ld_rd = 5'd9; rd = 5'd9; we = 4'hF; D = 32'h0000_0099; rt = 5'd9;
      edge_();
      ld_set = 1'b0; we = 4'h0;
      #1 chk("pend9_set_wins", 64'(t_wait), 64'd1);
      chk("r9_data", 64'(T), 64'h99);
      we = 4'h1; D = 32'h0000_0099;
      edge_();
      we = 4'h0;
      #1 chk("pend9_cleared", 64'(t_wait), 64'd0);

      // Same-cycle read of a register being written.
      rd = 5'd3; D = 32'h1122_3344; we = 4'hF;
      edge_();
      rs = 5'd3; rt = 5'd3; we = 4'b0011; D = 32'h0000_BEEF;
      #1 chk("byp_S", 64'(S), BYP ? 64'h1122_BEEF : 64'h1122_3344);
      chk("byp_T", 64'(T), BYP ? 64'h1122_BEEF : 64'h1122_3344);
      edge_();
      we = 4'h0;
      #1 chk("after_edge_S3", 64'(S), 64'h1122_BEEF);

      // Wide instance round trip.
      rd_b = 3'd6; we_b = 8'hFF; D_b = 64'h0123_4567_89AB_CDEF;
      edge_();
      we_b = 8'h00; rs_b = 3'd6; rt_b = 3'd6;
      #1 chk("b_S6", S_b, 64'h0123_4567_89AB_CDEF);
      chk("b_T6", T_b, 64'h0123_4567_89AB_CDEF);

      // Mid-run reset with r4 pending and holding 0x55.
      ld_set = 1'b1; ld_rd = 5'd4; rd = 5'd4; we = 4'hF; D = 32'h0000_0055; rs = 5'd4;
      edge_();
      ld_set = 1'b0; we = 4'h0;
      #1 chk("r4_data", 64'(S), 64'h55);
      chk("r4_pend", 64'(s_wait), 64'd1);
      rst_a = 1'b0;
      #1 chk("midrst_ready", 64'(ready), 64'd0);
      chk("midrst_swait", 64'(s_wait), 64'd0);
      chk("midrst_S", 64'(S), 64'd0);
      rst_a = 1'b1;
      for (int k = 1; k <= 31; k++) begin
         edge_();
         if (k == 30) chk("reclr_e30", 64'(ready), 64'd0);
         if (k == 31) chk("reclr_e31", 64'(ready), 64'd1);
      end
      #1 chk("reclr_r4", 64'(S), 64'd0);
      chk("reclr_pend4", 64'(s_wait), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
